// File: rtl/en_scheduler.sv
// en_scheduler
//   Round-robin step-enable scheduler for four clients. Each cycle it picks
//   at most one requesting client (searching from ptr upward, modulo 4) and
//   drives a registered one-hot grant plus a combined enable. A saturating
//   idle counter tracks how long pending requests have gone without a grant.
//   The starve output flags saturation.
//
//   Build option: FORCE_PROGRESS_EN
//     undefined : stall always blocks grants.
//     defined   : once the idle counter saturates, the next cycle grants
//                 despite stall, so en always eventually asserts.
//
// Ports
//   clk       in   clock, all state updates on posedge
//   rst       in   synchronous reset, active-low
//   req_i     in   [3:0] level request per client
//   stall_i   in   downstream hold-off, blocks normal grants
//   gnt_o     out  [3:0] registered one-hot (or zero) grant
//   en_o      out  registered, equal to |gnt_o
//   ptr_o     out  [1:0] client searched first on the next cycle
//   starve_o  out  registered, high while idle counter equals MAX_IDLE
module en_scheduler #(
   parameter int unsigned MAX_IDLE = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_i,
   input  logic       stall_i,
   output logic [3:0] gnt_o,
   output logic       en_o,
   output logic [1:0] ptr_o,
   output logic       starve_o
);

   localparam logic [3:0] IDLE_MAX = 4'(MAX_IDLE);

   logic [3:0] gnt_q, gnt_d;
   logic       en_q;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] idle_q, idle_d;
   logic       starve_q;

   logic [3:0] pick;
   logic [1:0] win_idx;
   logic [1:0] idx;
   logic       found;
   logic       allow;

   // Round-robin search starting at ptr_q; first set request wins.
   always_comb begin
      pick    = 4'b0000;
      win_idx = 2'd0;
      idx     = 2'd0;
      found   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req_i[idx]) begin
            found     = 1'b1;
            win_idx   = idx;
            pick[idx] = 1'b1;
         end
      end
   end

   always_comb begin
`ifdef FORCE_PROGRESS_EN
      // A saturated idle counter overrides stall for exactly one grant.
      allow = !stall_i || (idle_q == IDLE_MAX);
`else
      allow = !stall_i;
`endif
      gnt_d = allow ? pick : 4'b0000;
      ptr_d = ptr_q;
      if (allow && found) begin
         ptr_d = win_idx + 2'd1;
      end
      if ((req_i == 4'b0000) || (gnt_d != 4'b0000)) begin
         idle_d = 4'd0;
      end else if (idle_q >= IDLE_MAX) begin
         idle_d = IDLE_MAX;
      end else begin
         idle_d = idle_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt_q    <= 4'b0000;
         en_q     <= 1'b0;
         ptr_q    <= 2'd0;
         idle_q   <= 4'd0;
         starve_q <= 1'b0;
      end else begin
         gnt_q    <= gnt_d;
         en_q     <= |gnt_d;
         ptr_q    <= ptr_d;
         idle_q   <= idle_d;
         // Registered alongside idle_q so starve tracks it exactly.
         starve_q <= (idle_d == IDLE_MAX);
      end
   end

   assign gnt_o    = gnt_q;
   assign en_o     = en_q;
   assign ptr_o    = ptr_q;
   assign starve_o = starve_q;

   a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt_q) && (en_q == |gnt_q));
   a_starve_eq  : assert property (@(posedge clk) starve_q == (idle_q == IDLE_MAX));

`ifdef FORCE_PROGRESS_EN
`ifdef FORMAL
   a_progress : assert property (@(posedge clk) disable iff (!rst)
                                 (req_i != 4'b0000) |-> s_eventually en_q);
`endif
`endif

endmodule

// File: tb/tb_en_scheduler.sv
// Directed bench for en_scheduler (MAX_IDLE = 7). Inputs change 1 time unit
// after each rising edge; outputs are sampled at the same point.
module tb_en_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] req_i;
   logic       stall_i;
   logic [3:0] gnt_o;
   logic       en_o;
   logic [1:0] ptr_o;
   logic       starve_o;

   int checks   = 0;
   int failures = 0;

   en_scheduler #(.MAX_IDLE(7)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req_i),
      .stall_i  (stall_i),
      .gnt_o    (gnt_o),
      .en_o     (en_o),
      .ptr_o    (ptr_o),
      .starve_o (starve_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] p,
                          input logic s);
      chk({tag, ".gnt"},    gnt_o,            g);
      chk({tag, ".en"},     {3'b000, en_o},   {3'b000, |g});
      chk({tag, ".ptr"},    {2'b00, ptr_o},   {2'b00, p});
      chk({tag, ".starve"}, {3'b000, starve_o}, {3'b000, s});
   endtask

   initial begin
      logic [3:0] eg;
      logic [1:0] ep;

      // Reset held two cycles with all requests present.
      rst = 1'b0; req_i = 4'b1111; stall_i = 1'b0;
      cyc(); chk_all("rst0", 4'b0000, 2'd0, 1'b0);
      cyc(); chk_all("rst1", 4'b0000, 2'd0, 1'b0);

      // Release: before the next edge outputs still hold reset values.
      rst = 1'b1;
      #2; chk_all("rel_pre", 4'b0000, 2'd0, 1'b0);

      // Full rotation over 8 cycles.
      for (int i = 0; i < 8; i++) begin
         cyc();
         eg = 4'b0001 << (i % 4);
         ep = 2'((i + 1) % 4);
         chk_all($sformatf("rot%0d", i), eg, ep, 1'b0);
      end

      // Move ptr to 3, then skip and wrap with req=0101.
      req_i = 4'b0100;
      cyc(); chk_all("to_p3", 4'b0100, 2'd3, 1'b0);
      req_i = 4'b0101;
      cyc(); chk_all("wrap0", 4'b0001, 2'd1, 1'b0);
      cyc(); chk_all("wrap1", 4'b0100, 2'd3, 1'b0);

      // No requests: nothing granted, ptr holds.
      req_i = 4'b0000;
      cyc(); chk_all("noreq", 4'b0000, 2'd3, 1'b0);

      // Stall blocks, ptr holds, starve not yet.
      req_i = 4'b1111; stall_i = 1'b1;
      cyc(); chk_all("stall1", 4'b0000, 2'd3, 1'b0);

      // Request dropped under stall clears the idle count.
      req_i = 4'b0000;
      cyc(); chk_all("stall_noreq", 4'b0000, 2'd3, 1'b0);

      // ptr to 2 via client 1.
      req_i = 4'b0010; stall_i = 1'b0;
      cyc(); chk_all("to_p2", 4'b0010, 2'd2, 1'b0);

      // Mid-stream reset.
      req_i = 4'b1111; rst = 1'b0;
      cyc(); chk_all("mid_rst", 4'b0000, 2'd0, 1'b0);
      rst = 1'b1;
      cyc(); chk_all("post_rst", 4'b0001, 2'd1, 1'b0);

      // Starvation: client 1 alone, stall held.
      req_i = 4'b0010; stall_i = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         chk_all($sformatf("blk%0d", k), 4'b0000, 2'd1, (k == 7));
      end
`ifdef FORCE_PROGRESS_EN
      cyc(); chk_all("force_gnt", 4'b0010, 2'd2, 1'b0);
      cyc(); chk_all("force_after", 4'b0000, 2'd2, 1'b0);
`else
      cyc(); chk_all("starve_hold0", 4'b0000, 2'd1, 1'b1);
      cyc(); chk_all("starve_hold1", 4'b0000, 2'd1, 1'b1);
`endif

      // Stall released: single requester granted every cycle.
      stall_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk_all($sformatf("single%0d", k), 4'b0010, 2'd2, 1'b0);
      end

      // Fairness: client 0 waits behind 2 and 3 from ptr=2.
      req_i = 4'b1101;
      cyc(); chk_all("fair0", 4'b0100, 2'd3, 1'b0);
      cyc(); chk_all("fair1", 4'b1000, 2'd0, 1'b0);
      cyc(); chk_all("fair2", 4'b0001, 2'd1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/en_scheduler.md
EN_SCHEDULER -- requirements
Module: en_scheduler

Interface
REQ-001 Parameter MAX_IDLE, default 7, range 1..15; consecutive starved cycles before starve asserts.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  level request per client; bit i = client i wants one enable step.
REQ-005 stall  input  1  downstream hold-off; while 1, no normal grant issues.
REQ-006 gnt  output  4  registered one-hot grant; bit i high = client i steps this cycle.
REQ-007 en  output  1  registered, always equal to OR of gnt; the step enable driven to the stepped state machine.
REQ-008 ptr  output  2  round-robin priority pointer; client searched first next cycle.
REQ-009 starve  output  1  registered; high while pending requests have gone MAX_IDLE cycles without a grant.

Function
REQ-010 gnt SHALL be zero or one-hot every cycle; en SHALL equal |gnt every cycle.
REQ-011 Latency: req and stall sampled at posedge N SHALL produce gnt/en valid after posedge N, i.e. one register stage.
REQ-012 Arbitration when stall=0: search req from index ptr upward modulo 4 (ptr, ptr+1, ptr+2, ptr+3); grant the first set bit.
REQ-013 After a grant to client i, ptr SHALL become (i+1) mod 4; wrap 3 -> 0.
REQ-014 req=0000 or stall=1 without forced progress: gnt=0000, en=0, ptr unchanged.
REQ-015 Requests are level-sensitive; a client holding req high SHALL be re-granted whenever its turn recurs; no request drop is required between grants.
REQ-016 Single requester holding req high with stall=0 SHALL be granted every cycle.
REQ-017 Fairness bound: with stall=0, a client holding req high SHALL be granted within 4 cycles of first sampled assertion.
REQ-018 idle_cnt (internal, 4 bits): increments by 1 each cycle with |req=1 and no grant issued, saturating at MAX_IDLE; clears to 0 on any grant or when req=0000.
REQ-019 starve SHALL be 1 exactly when idle_cnt equals MAX_IDLE, else 0.
REQ-020 Request changing in the cycle it is granted: the sampled value decides; no grant is issued to a bit that was 0 at sampling.

Reset
REQ-021 rst=0 at a posedge: gnt=0000, en=0, ptr=00, idle_cnt=0, starve=0; overrides req and stall.
REQ-022 Reset mid-operation SHALL discard any pending arbitration; first grant after release SHALL follow REQ-012 from ptr=00.
REQ-023 First cycle after rst returns to 1: outputs reflect reset values; earliest grant appears one posedge later.

Configuration
REQ-024 Macro FORCE_PROGRESS_EN defined: when idle_cnt equals MAX_IDLE and |req=1, next cycle SHALL grant per REQ-012 despite stall=1, then clear idle_cnt; guarantees en eventually asserts under any stall pattern.
REQ-025 FORCE_PROGRESS_EN undefined: stall always blocks grants; starve SHALL stay 1 while stall=1 and |req=1 after saturation; no forced grant logic present.
REQ-026 Both builds SHALL otherwise be cycle-identical, including starve behaviour before saturation.

Verification
REQ-027 Reset: rst=0 two cycles with req=1111, stall=0 -> gnt=0000, en=0, ptr=00, starve=0 throughout.
REQ-028 Rotation: rst released, req=1111, stall=0 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; ptr 1,2,3,0,1,2,3,0.
REQ-029 Skip and wrap: ptr=3, req=0101 -> gnt=0001, ptr=1; next cycle gnt=0100, ptr=3.
REQ-030 Starvation: MAX_IDLE=7, req=0010, stall=1 held -> starve rises after 7th blocked cycle; with FORCE_PROGRESS_EN gnt=0010 next cycle and starve drops; without it gnt stays 0000 and starve stays 1.
REQ-031 Reset mid-stream: req=1111 running, ptr=2, rst=0 one cycle -> gnt=0000, ptr=00; after release first grant 0001.
REQ-032 Formal: SVA assert property gnt zero or one-hot and en==|gnt always; with FORCE_PROGRESS_EN and any req held high, s_eventually en SHALL prove without a fairness constraint on stall.
